alu_arbiter: RTL and testbench

- Shares the single 32-bit combinational ALU between two requesters, e.g. the main execute path (port 0) and the multi-cycle mult/div sequencer (port 1).
- Per requester: valid/ready request handshake and valid/ready response handshake.
- Latches operands, drives the ALU from registers, captures result and flags, and returns them only to the granted requester.
- Sits between the requesters and the ALU instance.

---
 rtl/alu_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Purpose:
//   Shares one 32-bit combinational ALU between two requesters (for example
//   the main execute path on port 0 and a mult/div sequencer on port 1).
//   A request is accepted with a valid/ready handshake. Its operands and
//   opcode are latched into registers that drive the ALU. One cycle later
//   the ALU result and flags are captured. They are returned with a
//   valid/ready response handshake to the granted port only.
//   Each operation takes three cycles: IDLE (accept), EXEC, RESP.
//   Operations never overlap.
//
// Parameters:
//   DATA_W    operand/result width; only 32 is supported.
//   PRIO_MODE 0 = round-robin between the two ports,
//             1 = fixed priority, port 0 always wins.
//
// Optional feature (macro ALU_ARB_OVF_EXC_EN):
//   When the macro is defined, rsp_exc is set if the captured result
//   overflowed on a signed ADD (0010) or SUB (0011). rsp_exc clears when
//   the arbiter returns to IDLE. When the macro is undefined, rsp_exc is
//   tied to 0. The overflow flag always appears in rsp_flags.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   req_valid/req_ready[1:0] per-port request handshake (bit i = port i)
//   req_a0/b0, req_a1/b1     per-port operands
//   req_aluc0/1              per-port opcode, passed through uninterpreted
//   rsp_valid/rsp_ready[1:0] per-port response handshake
//   rsp_r, rsp_flags         shared result and {zero,carry,negative,overflow}
//   rsp_exc                  signed overflow exception
//   alu_a, alu_b, alu_aluc   registered ALU inputs
//   alu_r, alu_zero, alu_carry, alu_negative, alu_overflow  ALU outputs

module alu_arbiter #(
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [3:0]        req_aluc0,
  input  logic [3:0]        req_aluc1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_r,
  output logic [3:0]        rsp_flags,
  output logic              rsp_exc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_aluc,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_negative,
  input  logic              alu_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic gnt_id;
  logic last_gnt;
  logic winner;
  logic accept;
  logic capture;
  logic retire;

  // Winner selection. The result only matters when at least one port is
  // valid. If only one port is valid, that port wins in either mode.
  // In round-robin mode a tie goes to the port that was not served last.
  always_comb begin
    winner = 1'b0;
    if (PRIO_MODE == 1) begin
      winner = ~req_valid[0];
    end else if (req_valid == 2'b11) begin
      winner = ~last_gnt;
    end else begin
      winner = ~req_valid[0];
    end
  end

  // Next-state and handshake outputs. In IDLE, ready is offered to the
  // winner, so any valid request completes its handshake in that cycle.
  // In RESP, only the granted port's rsp_ready can retire the operation.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    accept    = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready = winner ? 2'b10 : 2'b01;
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = gnt_id ? 2'b10 : 2'b01;
        if (rsp_ready[gnt_id]) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch and grant bookkeeping. last_gnt resets to 1 so that
  // port 0 wins the first contention after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_aluc <= 4'b0000;
      gnt_id   <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      if (accept) begin
        alu_a    <= winner ? req_a1 : req_a0;
        alu_b    <= winner ? req_b1 : req_b0;
        alu_aluc <= winner ? req_aluc1 : req_aluc0;
        gnt_id   <= winner;
      end
      if (retire) begin
        last_gnt <= gnt_id;
      end
    end
  end

  // Result capture at the end of EXEC. After that the result is held
  // untouched through RESP for as long as the requester backpressures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_r     <= '0;
      rsp_flags <= 4'b0000;
    end else if (capture) begin
      rsp_r     <= alu_r;
      rsp_flags <= {alu_zero, alu_carry, alu_negative, alu_overflow};
    end
  end

`ifdef ALU_ARB_OVF_EXC_EN
  // Only the signed ADD/SUB encodings trap. The wrapped result is still
  // returned, and the requester suppresses its write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_exc <= 1'b0;
    end else if (capture) begin
      rsp_exc <= alu_overflow & ((alu_aluc == 4'b0010) | (alu_aluc == 4'b0011));
    end else if (retire) begin
      rsp_exc <= 1'b0;
    end
  end
`else
  assign rsp_exc = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//
// Purpose:
//   Directed bench for alu_arbiter. The bench instantiates two arbiters
//   that share every input: one in round-robin mode (PRIO_MODE=0) and one
//   in fixed-priority mode (PRIO_MODE=1). Each arbiter drives its own
//   behavioural ALU stub. The signal 'sel' chooses which arbiter's outputs
//   the checks look at. Expected responses go into a queue when a grant is
//   seen, and are popped when rsp_valid is observed.
//
// Ports: none (top-level bench).

`timescale 1ns/1ps

module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_aluc0, req_aluc1;

  logic [1:0]  rr_req_ready, rr_rsp_valid;
  logic [31:0] rr_rsp_r, rr_alu_a, rr_alu_b, rr_alu_r;
  logic [3:0]  rr_rsp_flags, rr_alu_aluc;
  logic        rr_rsp_exc, rr_zero, rr_carry, rr_neg, rr_ovf;

  logic [1:0]  fp_req_ready, fp_rsp_valid;
  logic [31:0] fp_rsp_r, fp_alu_a, fp_alu_b, fp_alu_r;
  logic [3:0]  fp_rsp_flags, fp_alu_aluc;
  logic        fp_rsp_exc, fp_zero, fp_carry, fp_neg, fp_ovf;

  logic [1:0]  obs_req_ready, obs_rsp_valid;
  logic [31:0] obs_rsp_r, obs_alu_a, obs_alu_b;
  logic [3:0]  obs_rsp_flags, obs_alu_aluc;
  logic        obs_rsp_exc;

`ifdef ALU_ARB_OVF_EXC_EN
  localparam logic EXC_EXP = 1'b1;
`else
  localparam logic EXC_EXP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  vld;
    logic [31:0] r;
    logic [3:0]  flags;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural ALU: returns {zero, carry, negative, overflow, result}.
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
    logic [32:0] ext;
    logic [31:0] r;
    logic        cy, ov;
    ext = 33'd0;
    r   = 32'd0;
    cy  = 1'b0;
    ov  = 1'b0;
    case (c)
      4'b0000, 4'b0010: begin
        ext = {1'b0, a} + {1'b0, b};
        r   = ext[31:0];
        cy  = ext[32];
        ov  = (c == 4'b0010) && (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0001, 4'b0011: begin
        ext = {1'b0, a} - {1'b0, b};
        r   = ext[31:0];
        cy  = ext[32];
        ov  = (c == 4'b0011) && (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b1010: begin
        r  = (a < b) ? 32'd1 : 32'd0;
        cy = (a < b);
      end
      default: r = a & b;
    endcase
    return {(r == 32'd0), cy, r[31], ov, r};
  endfunction

  assign {rr_zero, rr_carry, rr_neg, rr_ovf, rr_alu_r} = alu_model(rr_alu_a, rr_alu_b, rr_alu_aluc);
  assign {fp_zero, fp_carry, fp_neg, fp_ovf, fp_alu_r} = alu_model(fp_alu_a, fp_alu_b, fp_alu_aluc);

  assign obs_req_ready = sel ? fp_req_ready : rr_req_ready;
  assign obs_rsp_valid = sel ? fp_rsp_valid : rr_rsp_valid;
  assign obs_rsp_r     = sel ? fp_rsp_r     : rr_rsp_r;
  assign obs_rsp_flags = sel ? fp_rsp_flags : rr_rsp_flags;
  assign obs_rsp_exc   = sel ? fp_rsp_exc   : rr_rsp_exc;
  assign obs_alu_a     = sel ? fp_alu_a     : rr_alu_a;
  assign obs_alu_b     = sel ? fp_alu_b     : rr_alu_b;
  assign obs_alu_aluc  = sel ? fp_alu_aluc  : rr_alu_aluc;

  alu_arbiter #(.DATA_W(32), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rr_req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_aluc0(req_aluc0), .req_aluc1(req_aluc1),
    .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rr_rsp_r), .rsp_flags(rr_rsp_flags), .rsp_exc(rr_rsp_exc),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_aluc(rr_alu_aluc),
    .alu_r(rr_alu_r), .alu_zero(rr_zero), .alu_carry(rr_carry),
    .alu_negative(rr_neg), .alu_overflow(rr_ovf)
  );

  alu_arbiter #(.DATA_W(32), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_aluc0(req_aluc0), .req_aluc1(req_aluc1),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(fp_rsp_r), .rsp_flags(fp_rsp_flags), .rsp_exc(fp_rsp_exc),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_aluc(fp_alu_aluc),
    .alu_r(fp_alu_r), .alu_zero(fp_zero), .alu_carry(fp_carry),
    .alu_negative(fp_neg), .alu_overflow(fp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to the next sampling point, a little after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rdy);
    req_valid = valid;
    rsp_ready = rdy;
    #1;
  endtask

  task automatic setOperands(input logic port, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] c);
    if (port) begin
      req_a1 = a; req_b1 = b; req_aluc1 = c;
    end else begin
      req_a0 = a; req_b0 = b; req_aluc0 = c;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    failures++;
    $error("[TB] FAIL %s observed=timeout expected=event", tag);
  endtask

  // Pop the oldest expected response and compare it with the current
  // response outputs.
  task automatic checkResponse(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      timeoutFail({tag, "_scoreboard_empty"});
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, "_rsp_valid"}, 32'(obs_rsp_valid), 32'(e.vld));
      checkOutput({tag, "_rsp_r"},     obs_rsp_r,          e.r);
      checkOutput({tag, "_rsp_flags"}, 32'(obs_rsp_flags), 32'(e.flags));
      checkOutput({tag, "_rsp_exc"},   32'(obs_rsp_exc),   32'(e.exc));
    end
  endtask

  // Wait, starting with the current cycle, for a grant. Then check which
  // port was granted and queue the response expected for that operation.
  task automatic acceptOne(input string tag, input logic [1:0] exp_ready, input logic [31:0] r,
                           input logic [3:0] flags, input logic exc, input int budget);
    int n = 0;
    while (obs_req_ready == 2'b00 && n < budget) begin
      step();
      n++;
    end
    if (obs_req_ready == 2'b00) begin
      timeoutFail(tag);
    end else begin
      checkOutput(tag, 32'(obs_req_ready), 32'(exp_ready));
      exp_q.push_back('{vld: exp_ready, r: r, flags: flags, exc: exc});
    end
  endtask

  task automatic retireOne(input string tag, input int budget);
    int n = 0;
    while (obs_rsp_valid == 2'b00 && n < budget) begin
      step();
      n++;
    end
    if (obs_rsp_valid == 2'b00) timeoutFail(tag);
    else checkResponse(tag);
  endtask

  initial begin
    sel = 1'b0;
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    setOperands(1'b0, 32'd0, 32'd0, 4'b0000);
    setOperands(1'b1, 32'd0, 32'd0, 4'b0000);

    // Reset state.
    repeat (2) step();
    $display("[TB] reset values");
    checkOutput("rst_req_ready", 32'(obs_req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    checkOutput("rst_rsp_r",     obs_rsp_r,          32'd0);
    checkOutput("rst_rsp_flags", 32'(obs_rsp_flags), 32'd0);
    checkOutput("rst_rsp_exc",   32'(obs_rsp_exc),   32'd0);
    checkOutput("rst_alu_a",     obs_alu_a,          32'd0);
    checkOutput("rst_alu_b",     obs_alu_b,          32'd0);
    checkOutput("rst_alu_aluc",  32'(obs_alu_aluc),  32'd0);
    rst = 1'b0;

    // ADDU on port 0. Check the response latency cycle by cycle.
    $display("[TB] ADDU latency");
    step();
    setOperands(1'b0, 32'd5, 32'd7, 4'b0000);
    applyStimulus(2'b01, 2'b00);
    acceptOne("addu_grant", 2'b01, 32'd12, 4'b0000, 1'b0, 0);
    step();
    applyStimulus(2'b00, 2'b00);
    checkOutput("addu_t1_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    checkOutput("addu_t1_alu_a",     obs_alu_a,          32'd5);
    checkOutput("addu_t1_alu_b",     obs_alu_b,          32'd7);
    checkOutput("addu_t1_alu_aluc",  32'(obs_alu_aluc),  32'd0);
    step();
    checkResponse("addu_t2");
    applyStimulus(2'b00, 2'b01);
    step();
    checkOutput("addu_done_rsp_valid", 32'(obs_rsp_valid), 32'd0);

    // Round-robin: both ports valid continuously from reset.
    $display("[TB] round-robin contention");
    rst = 1'b1;
    step();
    rst = 1'b0;
    setOperands(1'b0, 32'd5, 32'd7, 4'b0000);
    setOperands(1'b1, 32'd3, 32'd5, 4'b1010);
    applyStimulus(2'b11, 2'b11);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) acceptOne("rr_grant_p0", 2'b01, 32'd12, 4'b0000, 1'b0, 5);
      else            acceptOne("rr_grant_p1", 2'b10, 32'd1,  4'b0100, 1'b0, 5);
      retireOne("rr_rsp", 5);
    end

    // Signed ADD overflow on port 1.
    $display("[TB] signed overflow");
    step();
    setOperands(1'b1, 32'h7FFF_FFFF, 32'd1, 4'b0010);
    applyStimulus(2'b10, 2'b10);
    acceptOne("ovf_grant", 2'b10, 32'h8000_0000, 4'b0011, EXC_EXP, 0);
    step();
    applyStimulus(2'b00, 2'b10);
    retireOne("ovf_rsp", 4);

    // Backpressure on port 0 while port 1 waits. Port 1's rsp_ready is
    // high during the hold and must be ignored.
    $display("[TB] backpressure");
    step();
    setOperands(1'b0, 32'd10, 32'd3, 4'b0001);
    setOperands(1'b1, 32'd100, 32'd23, 4'b0000);
    applyStimulus(2'b01, 2'b00);
    acceptOne("bp_grant_p0", 2'b01, 32'd7, 4'b0000, 1'b0, 0);
    step();
    applyStimulus(2'b10, 2'b10);
    step();
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_hold_req_ready", 32'(obs_req_ready), 32'd0);
      checkOutput("bp_hold_rsp_valid", 32'(obs_rsp_valid), 32'd1);
      checkOutput("bp_hold_rsp_r",     obs_rsp_r,          32'd7);
      checkOutput("bp_hold_rsp_flags", 32'(obs_rsp_flags), 32'd0);
      step();
    end
    checkResponse("bp_rsp_p0");
    applyStimulus(2'b10, 2'b11);
    step();
    acceptOne("bp_grant_p1", 2'b10, 32'd123, 4'b0000, 1'b0, 0);
    step();
    applyStimulus(2'b00, 2'b10);
    retireOne("bp_rsp_p1", 4);

    // Reset during EXEC. The in-flight result is discarded.
    $display("[TB] reset mid-operation");
    step();
    setOperands(1'b0, 32'd5, 32'd7, 4'b0000);
    applyStimulus(2'b01, 2'b00);
    checkOutput("midrst_grant", 32'(obs_req_ready), 32'd1);
    step();
    applyStimulus(2'b00, 2'b00);
    checkOutput("midrst_exec_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    rst = 1'b1;
    step();
    checkOutput("midrst_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    checkOutput("midrst_rsp_r",     obs_rsp_r,          32'd0);
    checkOutput("midrst_alu_a",     obs_alu_a,          32'd0);
    rst = 1'b0;
    setOperands(1'b1, 32'd3, 32'd5, 4'b1010);
    applyStimulus(2'b11, 2'b11);
    acceptOne("midrst_first_grant", 2'b01, 32'd12, 4'b0000, 1'b0, 0);
    retireOne("midrst_rsp", 4);

    // Fixed priority: port 0 wins every contention until it drops.
    $display("[TB] fixed priority");
    sel = 1'b1;
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00);
    repeat (2) step();
    rst = 1'b0;
    setOperands(1'b0, 32'd5, 32'd7, 4'b0000);
    setOperands(1'b1, 32'd3, 32'd5, 4'b1010);
    applyStimulus(2'b11, 2'b11);
    for (int i = 0; i < 3; i++) begin
      acceptOne("fp_grant_p0", 2'b01, 32'd12, 4'b0000, 1'b0, 5);
      retireOne("fp_rsp_p0", 5);
    end
    applyStimulus(2'b10, 2'b11);
    acceptOne("fp_grant_p1", 2'b10, 32'd1, 4'b0100, 1'b0, 5);
    step();
    applyStimulus(2'b00, 2'b11);
    retireOne("fp_rsp_p1", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
